// File: rtl/mem_pkg.sv
// Shared defaults for the multi-port LVT memory plus the live-value-table width helper.
// Build option: MEM_WR_BYPASS_EN selects write-first read data in mem_nr_nw_lvt.
package mem_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 11;
  localparam int NR_DEF = 2;
  localparam int NW_DEF = 2;

  // Bits needed to name a write port; a single writer still gets a 1-bit field.
  function automatic int lvt_w(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

  localparam int LVT_W_DEF = lvt_w(NW_DEF);

endpackage

// File: rtl/mem_lvt.sv
// Live-value table: remembers which write port last wrote each word; flop storage,
// combinational lookup for every read address, cleared asynchronously by rst.
module mem_lvt
  import mem_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int NW  = NW_DEF,
  parameter int NRD = NR_DEF + NW_DEF,
  parameter int LW  = LVT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NW-1:0]     we,
  input  logic [NW*AW-1:0]  w_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*LW-1:0] rd_sel
);

  localparam int DEPTH = 1 << AW;

  logic [LW-1:0] lvt [DEPTH];

  // Enabled writers arrive with distinct addresses, so loop order never matters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) lvt[a] <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we[k]) lvt[w_addr[k*AW +: AW]] <= LW'(k);
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NRD; i++) rd_sel[i*LW +: LW] = lvt[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/mem_nr_nw_lvt.sv
// NR-read / NW-write memory built from per-port banks steered by a live-value table.
// Build option: MEM_WR_BYPASS_EN makes r_data/dw show same-edge winning write data.
module mem_nr_nw_lvt
  import mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF,
  parameter int NW = NW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    en_w,
  input  logic [NW*AW-1:0] w_addr,
  input  logic [NW*DW-1:0] w_data,
  input  logic [NR*AW-1:0] r_addr,
  output logic [NR*DW-1:0] r_data,
  output logic [NW*DW-1:0] dw,
  output logic             w_coll
);

  localparam int DEPTH = 1 << AW;
  localparam int NRD   = NR + NW;
  localparam int LW    = lvt_w(NW);

  // Lookup slots 0..NR-1 are the read ports, NR..NRD-1 the write-address read-backs.
  logic [NRD*AW-1:0]            rd_addr;
  logic [NW-1:0]                win;
  logic [NW-1:0][NRD*DW-1:0]    bank_rd;
  logic [NRD*DW-1:0]            rd_mux;
  logic [NRD*DW-1:0]            rd_next;

  assign rd_addr = {w_addr, r_addr};

  // Lowest enabled port owns a contested address; the others are dropped entirely.
  always_comb begin
    win = en_w;
    for (int k = 1; k < NW; k++) begin
      for (int j = 0; j < k; j++) begin
        if (en_w[j] && en_w[k] && (w_addr[j*AW +: AW] == w_addr[k*AW +: AW])) win[k] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      end else if (win[k]) begin
        mem[w_addr[k*AW +: AW]] <= w_data[k*DW +: DW];
      end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign bank_rd[k][i*DW +: DW] = mem[rd_addr[i*AW +: AW]];
    end
  end

  if (NW > 1) begin : g_lvt
    logic [NRD*LW-1:0] lvt_sel;

    mem_lvt #(
      .AW  (AW),
      .NW  (NW),
      .NRD (NRD),
      .LW  (LW)
    ) u_lvt (
      .clk     (clk),
      .rst     (rst),
      .we      (win),
      .w_addr  (w_addr),
      .rd_addr (rd_addr),
      .rd_sel  (lvt_sel)
    );

    always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NRD; i++) rd_mux[i*DW +: DW] = bank_rd[lvt_sel[i*LW +: LW]][i*DW +: DW];
    end
  end else begin : g_no_lvt
    assign rd_mux = bank_rd[0];
  end

  always_comb begin
    rd_next = rd_mux;
`ifdef MEM_WR_BYPASS_EN
    for (int i = 0; i < NRD; i++) begin
      for (int k = 0; k < NW; k++) begin
        if (win[k] && (rd_addr[i*AW +: AW] == w_addr[k*AW +: AW])) rd_next[i*DW +: DW] = w_data[k*DW +: DW];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      dw     <= '0;
      w_coll <= 1'b0;
    end else begin
      r_data <= rd_next[NR*DW-1:0];
      dw     <= rd_next[NRD*DW-1:NR*DW];
      w_coll <= |(en_w & ~win);
    end
  end

endmodule

// File: tb/tb_mem_nr_nw_lvt.sv
// Directed bench for mem_nr_nw_lvt at default parameters (DW=32, AW=11, NR=2, NW=2).
module tb_mem_nr_nw_lvt;

  localparam int DW = 32;
  localparam int AW = 11;

  logic            clk;
  logic            rst;
  logic [1:0]      en_w;
  logic [2*AW-1:0] w_addr;
  logic [2*DW-1:0] w_data;
  logic [2*AW-1:0] r_addr;
  logic [2*DW-1:0] r_data;
  logic [2*DW-1:0] dw;
  logic            w_coll;

  int n_cmp;
  int n_bad;

  logic [DW-1:0] model [2048];

  mem_nr_nw_lvt dut (
    .clk    (clk),
    .rst    (rst),
    .en_w   (en_w),
    .w_addr (w_addr),
    .w_data (w_data),
    .r_addr (r_addr),
    .r_data (r_data),
    .dw     (dw),
    .w_coll (w_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read at that same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input int wa0, input int wd0, input int wa1, input int wd1,
                       input int ra0, input int ra1);
    en_w   = en;
    w_addr = {AW'(wa1), AW'(wa0)};
    w_data = {DW'(wd1), DW'(wd0)};
    r_addr = {AW'(ra1), AW'(ra0)};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    n_cmp++;
    if (r_data !== '0 || dw !== '0 || w_coll !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: r_data=%h dw=%h w_coll=%b, required all zero", r_data, dw, w_coll);
    end
    rst = 1'b1;
    for (int a = 0; a < 2048; a += 2) begin
      drive(2'b00, a, 0, a + 1, 0, a, a + 1);
      cyc();
      n_cmp++;
      if (r_data !== '0 || dw !== '0) begin
        n_bad++;
        $display("FAIL reset_sweep addr %0d: r_data=%h dw=%h, required 0", a, r_data, dw);
      end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] same_edge;
`ifdef MEM_WR_BYPASS_EN
    same_edge = 32'hA5;
`else
    same_edge = 32'h0;
`endif
    drive(2'b01, 5, 32'hA5, 6, 0, 5, 0);
    cyc();
    n_cmp++;
    if (r_data[31:0] !== same_edge || dw[31:0] !== same_edge) begin
      n_bad++;
      $display("FAIL same_edge_read: r_data0=%h dw0=%h, required %h", r_data[31:0], dw[31:0], same_edge);
    end
    drive(2'b00, 5, 0, 0, 0, 5, 5);
    cyc();
    n_cmp++;
    if (r_data !== {32'hA5, 32'hA5} || dw[31:0] !== 32'hA5) begin
      n_bad++;
      $display("FAIL write_then_read: r_data=%h dw0=%h, required both 000000a5", r_data, dw[31:0]);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] same_edge;
`ifdef MEM_WR_BYPASS_EN
    same_edge = 32'h11;
`else
    same_edge = 32'h0;
`endif
    drive(2'b11, 100, 32'h11, 100, 32'h22, 0, 0);
    cyc();
    n_cmp++;
    if (w_coll !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_flag: w_coll=%b, required 1", w_coll);
    end
    n_cmp++;
    if (dw !== {same_edge, same_edge}) begin
      n_bad++;
      $display("FAIL collision_dw: dw=%h, required %h%h", dw, same_edge, same_edge);
    end
    drive(2'b00, 0, 0, 0, 0, 100, 100);
    cyc();
    n_cmp++;
    if (w_coll !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_one_cycle: w_coll=%b, required 0", w_coll);
    end
    n_cmp++;
    if (r_data !== {32'h11, 32'h11}) begin
      n_bad++;
      $display("FAIL collision_winner: r_data=%h, required both 00000011", r_data);
    end
  endtask

  task automatic test_lvt_switch();
    logic [DW-1:0] same_edge;
`ifdef MEM_WR_BYPASS_EN
    same_edge = 32'h44;
`else
    same_edge = 32'h33;
`endif
    drive(2'b10, 0, 0, 7, 32'h33, 0, 0);
    cyc();
    n_cmp++;
    if (w_coll !== 1'b0) begin
      n_bad++;
      $display("FAIL lvt_no_coll: w_coll=%b, required 0", w_coll);
    end
    drive(2'b01, 7, 32'h44, 7, 0, 0, 0);
    cyc();
    n_cmp++;
    if (dw[63:32] !== same_edge) begin
      n_bad++;
      $display("FAIL lvt_dw1_pre: dw1=%h, required %h", dw[63:32], same_edge);
    end
    drive(2'b00, 0, 0, 7, 0, 7, 7);
    cyc();
    n_cmp++;
    if (r_data !== {32'h44, 32'h44} || dw[63:32] !== 32'h44) begin
      n_bad++;
      $display("FAIL lvt_latest_writer: r_data=%h dw1=%h, required 00000044", r_data, dw[63:32]);
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b11, 10, 32'h01, 11, 32'h02, 0, 0);
    cyc();
    drive(2'b11, 11, 32'h03, 10, 32'h04, 0, 0);
    cyc();
    n_cmp++;
    if (w_coll !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_no_coll: w_coll=%b, required 0", w_coll);
    end
    drive(2'b00, 10, 0, 11, 0, 10, 11);
    cyc();
    n_cmp++;
    if (r_data !== {32'h03, 32'h04} || dw !== {32'h03, 32'h04}) begin
      n_bad++;
      $display("FAIL b2b_readback: r_data=%h dw=%h, required 0000000300000004", r_data, dw);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b01, 2047, 32'hFF, 0, 0, 0, 0);
    cyc();
    drive(2'b00, 0, 0, 0, 0, 2047, 2047);
    cyc();
    n_cmp++;
    if (r_data !== {32'hFF, 32'hFF}) begin
      n_bad++;
      $display("FAIL top_addr_write: r_data=%h, required both 000000ff", r_data);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (r_data !== '0 || dw !== '0) begin
      n_bad++;
      $display("FAIL async_clear: r_data=%h dw=%h, required 0", r_data, dw);
    end
    drive(2'b01, 3, 32'h77, 0, 0, 3, 3);
    cyc();
    rst = 1'b1;
    drive(2'b00, 3, 0, 5, 0, 2047, 3);
    cyc();
    n_cmp++;
    if (r_data !== '0 || dw !== '0) begin
      n_bad++;
      $display("FAIL after_reset_reads: r_data=%h dw=%h, required 0", r_data, dw);
    end
  endtask

  task automatic test_random();
    logic [1:0]    en;
    int            wa [2];
    int            ra [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] exp_r [2];
    logic [DW-1:0] exp_d [2];
    logic          exp_c;
    logic [1:0]    wins;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int a = 0; a < 2048; a++) model[a] = '0;
    for (int n = 0; n < 3000; n++) begin
      en = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        wa[p] = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 15));
        ra[p] = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 15));
        wd[p] = DW'($urandom_range(0, 255));
      end
      wins  = en;
      if (en == 2'b11 && wa[0] == wa[1]) wins = 2'b01;
      exp_c = (wins != en);
      for (int p = 0; p < 2; p++) begin
        exp_r[p] = model[ra[p]];
        exp_d[p] = model[wa[p]];
`ifdef MEM_WR_BYPASS_EN
        for (int k = 1; k >= 0; k--) begin
          if (wins[k] && ra[p] == wa[k]) exp_r[p] = wd[k];
          if (wins[k] && wa[p] == wa[k]) exp_d[p] = wd[k];
        end
`endif
      end
      for (int k = 0; k < 2; k++) if (wins[k]) model[wa[k]] = wd[k];
      drive(en, wa[0], int'(wd[0]), wa[1], int'(wd[1]), ra[0], ra[1]);
      cyc();
      n_cmp++;
      if (r_data !== {exp_r[1], exp_r[0]} || dw !== {exp_d[1], exp_d[0]} || w_coll !== exp_c) begin
        n_bad++;
        $display("FAIL random cycle %0d: r_data=%h dw=%h w_coll=%b, required %h%h %h%h %b",
                 n, r_data, dw, w_coll, exp_r[1], exp_r[0], exp_d[1], exp_d[0], exp_c);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_write_read();
    test_collision();
    test_lvt_switch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
